// File: rtl/column_drain.sv
// Snapshots one accumulator column on load_i and streams its N words oldest-first, one per valid/ready beat.
// Load-to-first-valid is 1 cycle. Outputs hold while ready_i is low. A new load is taken on the last beat, or the load is dropped and flagged.
module column_drain #(
    parameter int NUM_BITS = 32,
    parameter int N        = 4,
    localparam int IW      = $clog2(N)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [N-1:0][NUM_BITS-1:0]   product_i,
    input  logic                         load_i,
    output logic                         load_ready_o,
    output logic [NUM_BITS-1:0]          data_o,
    output logic [IW-1:0]                idx_o,
    output logic                         last_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic                         busy_o,
    output logic                         overflow_o,
    input  logic                         clear_err_i
);

    typedef enum logic {IDLE, DRAIN} state_t;

    localparam logic [IW-1:0] PTR_TOP = IW'(N - 1);

    state_t                      state, state_nx;
    logic [N-1:0][NUM_BITS-1:0]  snap;
    logic [IW-1:0]               ptr;
    logic                        draining;
    logic                        at_last;
    logic                        accept;
    logic                        drop;

    assign draining = (state == DRAIN);
    assign at_last  = (ptr == '0);
    assign accept   = load_i && load_ready_o;
    assign drop     = load_i && !load_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = DRAIN;
            DRAIN:   if (ready_i && at_last && !accept) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A capture on the final handshake restarts the pointer, giving back-to-back drains.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            snap <= '0;
            ptr  <= '0;
        end else if (accept) begin
            snap <= product_i;
            ptr  <= PTR_TOP;
        end else if (draining && ready_i && !at_last) begin
            ptr  <= ptr - 1'b1;
        end
    end

    // A drop in the same cycle as a clear keeps the error flag set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_o <= 1'b0;
        end else if (drop) begin
            overflow_o <= 1'b1;
        end else if (clear_err_i) begin
            overflow_o <= 1'b0;
        end
    end

    always_comb begin
        load_ready_o = !draining || (at_last && ready_i);
        valid_o      = draining;
        busy_o       = draining;
        last_o       = draining && at_last;
        data_o       = draining ? snap[ptr] : '0;
        idx_o        = draining ? ptr : '0;
    end

endmodule

// File: tb/tb_column_drain.sv
// Randomised and directed bench for column_drain with a queue-based model of pending beats.
module tb_column_drain;

    localparam int NB = 8;
    localparam int N  = 4;

    logic              clk;
    logic              rst_n;
    logic [N-1:0][NB-1:0] prod;
    logic              load;
    logic              load_ready;
    logic [NB-1:0]     data;
    logic [1:0]        idx;
    logic              last;
    logic              valid;
    logic              ready;
    logic              busy;
    logic              ovf;
    logic              clr;

    column_drain #(.NUM_BITS(NB), .N(N)) dut (
        .clk_i(clk), .rst_ni(rst_n), .product_i(prod), .load_i(load),
        .load_ready_o(load_ready), .data_o(data), .idx_o(idx), .last_o(last),
        .valid_o(valid), .ready_i(ready), .busy_o(busy), .overflow_o(ovf),
        .clear_err_i(clr)
    );

    typedef struct packed {
        logic [NB-1:0] d;
        logic [1:0]    i;
        logic          l;
    } beat_t;

    beat_t mq[$];
    beat_t log_q[$];
    logic  m_ovf;
    int    checks;
    int    failures;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the pending beats of the current drain, oldest-first.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            logic lr;
            lr = (mq.size() == 0) || (mq.size() == 1 && ready);
            if (mq.size() > 0 && ready) void'(mq.pop_front());
            if (load && lr) begin
                for (int k = N - 1; k >= 0; k--) begin
                    beat_t b;
                    b.d = prod[k];
                    b.i = 2'(k);
                    b.l = (k == 0);
                    mq.push_back(b);
                end
            end
            if (load && !lr) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid", {31'd0, valid}, 0);
            chk("rst_busy", {31'd0, busy}, 0);
            chk("rst_ovf", {31'd0, ovf}, 0);
            chk("rst_data", {24'd0, data}, 0);
            chk("rst_last", {31'd0, last}, 0);
        end else begin
            chk("m_valid", {31'd0, valid}, {31'd0, mq.size() > 0});
            chk("m_busy", {31'd0, busy}, {31'd0, mq.size() > 0});
            chk("m_ovf", {31'd0, ovf}, {31'd0, m_ovf});
            chk("m_load_ready", {31'd0, load_ready},
                {31'd0, (mq.size() == 0) || (mq.size() == 1 && ready)});
            if (mq.size() > 0) begin
                chk("m_data", {24'd0, data}, {24'd0, mq[0].d});
                chk("m_idx", {30'd0, idx}, {30'd0, mq[0].i});
                chk("m_last", {31'd0, last}, {31'd0, mq[0].l});
            end
            if (valid && ready) begin
                beat_t b;
                b.d = data;
                b.i = idx;
                b.l = last;
                log_q.push_back(b);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        step();
        while (busy && n < 100) begin
            step();
            n++;
        end
        if (busy) begin
            failures++;
            $display("FAIL wait_idle timeout busy=%0b", busy);
        end
    endtask

    task automatic chk_basic_log(input string nm);
        chk({nm, "_count"}, log_q.size(), 4);
        for (int k = 0; k < 4 && k < log_q.size(); k++) begin
            chk({nm, "_data"}, {24'd0, log_q[k].d}, 32'h44 - 32'h11 * k);
            chk({nm, "_idx"}, {30'd0, log_q[k].i}, 3 - k);
            chk({nm, "_last"}, {31'd0, log_q[k].l}, {31'd0, k == 3});
        end
    endtask

    localparam logic [N-1:0][NB-1:0] BASIC = {8'h44, 8'h33, 8'h22, 8'h11};
    localparam logic [N-1:0][NB-1:0] NEXT  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    initial begin
        int n;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        prod = '0;
        load = 1'b0;
        ready = 1'b0;
        clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", {31'd0, valid}, 0);
        chk("reset_data", {24'd0, data}, 0);
        step();
        rst_n = 1'b1;
        repeat (10) begin
            step();
            chk("idle_valid", {31'd0, valid}, 0);
        end

        // Basic drain
        log_q.delete();
        prod = BASIC;
        ready = 1'b1;
        load = 1'b1;
        step();
        load = 1'b0;
        chk("first_data", {24'd0, data}, 32'h44);
        wait_idle();
        chk_basic_log("basic");
        chk("basic_end_valid", {31'd0, valid}, 0);

        // Backpressure on the 0x33 beat; product changes after the snapshot
        log_q.delete();
        load = 1'b1;
        step();
        load = 1'b0;
        prod = '1;
        step();
        chk("bp_idx_before", {30'd0, idx}, 2);
        ready = 1'b0;
        repeat (3) begin
            step();
            chk("bp_hold_data", {24'd0, data}, 32'h33);
            chk("bp_hold_idx", {30'd0, idx}, 2);
            chk("bp_hold_valid", {31'd0, valid}, 1);
        end
        ready = 1'b1;
        wait_idle();
        chk_basic_log("bp");

        // Back-to-back drains
        log_q.delete();
        prod = BASIC;
        load = 1'b1;
        step();
        load = 1'b0;
        n = 0;
        while (!last && n < 20) begin
            step();
            n++;
        end
        chk("b2b_reached_last", {31'd0, last}, 1);
        prod = NEXT;
        load = 1'b1;
        #1;
        chk("b2b_load_ready", {31'd0, load_ready}, 1);
        step();
        load = 1'b0;
        chk("b2b_valid", {31'd0, valid}, 1);
        chk("b2b_data", {24'd0, data}, 32'hA3);
        chk("b2b_idx", {30'd0, idx}, 3);
        wait_idle();
        chk("b2b_count", log_q.size(), 8);

        // Overflow: drop on the second beat, then clear, then drop+clear
        log_q.delete();
        prod = BASIC;
        load = 1'b1;
        step();
        load = 1'b0;
        step();
        load = 1'b1;
        step();
        load = 1'b0;
        chk("ovf_set", {31'd0, ovf}, 1);
        wait_idle();
        chk_basic_log("ovf");
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("ovf_cleared", {31'd0, ovf}, 0);
        load = 1'b1;
        step();
        clr = 1'b1;
        step();
        load = 1'b0;
        clr = 1'b0;
        chk("ovf_set_wins", {31'd0, ovf}, 1);
        wait_idle();
        clr = 1'b1;
        step();
        clr = 1'b0;

        // Asynchronous reset mid-drain
        load = 1'b1;
        step();
        load = 1'b0;
        step();
        chk("mid_idx", {30'd0, idx}, 2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, valid}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        step();
        step();
        rst_n = 1'b1;
        repeat (6) begin
            step();
            chk("post_rst_valid", {31'd0, valid}, 0);
        end

        // Random traffic against the model
        repeat (600) begin
            ready = ($urandom_range(0, 3) != 0);
            load  = ($urandom_range(0, 4) == 0);
            clr   = ($urandom_range(0, 15) == 0);
            prod  = $urandom;
            step();
        end
        load = 1'b0;
        clr = 1'b0;
        ready = 1'b1;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/column_drain.md
Name: column_drain

Overview:
- Output stage directly downstream of one accumulator column of the systolic matrix-multiply array.
- On a load pulse, takes a snapshot of the column's N result registers, then streams them out one word per beat over a valid/ready interface.
- Frees the accumulator column for the next tile as soon as the snapshot is taken.
- One instance per column. Results are serialised toward the writeback/output path.

Parameters:
- NUM_BITS, default pkg NUM_BITS (32): width of each result word.
- N, default pkg N (4): number of result registers per column. Must be 2 or more.

Ports:
- clk_i  in  1  clock; all logic is rising-edge.
- rst_ni  in  1  asynchronous active-low reset.
- product_i  in  NUM_BITS x [N]  column result registers. Index 0 is the newest entry, index N-1 the oldest.
- load_i  in  1  one-cycle request to snapshot product_i.
- load_ready_o  out  1  a load in this cycle will be accepted.
- data_o  out  NUM_BITS  current output word.
- idx_o  out  $clog2(N)  index of product_i that data_o came from.
- last_o  out  1  current beat is the final word (idx_o == 0).
- valid_o  out  1  data_o/idx_o/last_o are valid.
- ready_i  in  1  consumer accepts the beat when valid_o && ready_i.
- busy_o  out  1  drain is in progress (state DRAIN).
- overflow_o  out  1  sticky error: a load was dropped.
- clear_err_i  in  1  clears overflow_o.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - State goes to IDLE.
  - valid_o, busy_o, overflow_o, last_o = 0. data_o = 0. idx_o = 0. Snapshot registers = 0.
  - Reset asserted mid-drain abandons the drain immediately. No further beats are issued after release.
- FSM states: IDLE and DRAIN.
- IDLE:
  - load_ready_o = 1.
  - If load_i: capture all N words of product_i into the snapshot. Set the pointer to N-1. Go to DRAIN.
  - valid_o rises on the next cycle, so latency from load to first valid is 1 cycle.
- DRAIN:
  - valid_o = 1. data_o = snapshot[ptr]. idx_o = ptr. last_o = (ptr == 0).
  - Drain order is oldest first: N-1, N-2, ..., 0.
  - Beat accepted (valid_o && ready_i) with ptr > 0: ptr decrements, and the next word is presented the following cycle.
  - No handshake: data_o, idx_o, last_o and valid_o hold stable. valid_o never drops before acceptance.
  - Last beat accepted (ptr == 0 && ready_i):
    - If load_i in the same cycle: capture the new snapshot, ptr = N-1, stay in DRAIN. This gives back-to-back drains with no bubble.
    - Otherwise go to IDLE.
- load_ready_o = (state == IDLE) || (state == DRAIN && last_o && ready_i). This is combinational from ready_i.
- Throughput: 1 word/cycle with ready_i held high. One column of N words drains in N cycles.
- Dropped load (load_i && !load_ready_o):
  - Snapshot and drain are unaffected.
  - overflow_o is set on the next edge.
- overflow_o clearing:
  - clear_err_i clears overflow_o on the next edge.
  - A drop and a clear in the same cycle leave overflow_o = 1 (set wins).
- Snapshot content:
  - Captured exactly from product_i at the accepting edge.
  - Later changes on product_i (the accumulator shifting new C values in) do not affect words being drained.
- No arithmetic. Data is passed through unmodified at full NUM_BITS width.

Test Plan:
- Reset/idle: with rst_ni low, check valid_o=0, busy_o=0, overflow_o=0, data_o=0. Release reset with no load; valid_o stays 0 for 10 cycles.
- Basic drain (N=4, NUM_BITS=8): product_i = {0:0x11, 1:0x22, 2:0x33, 3:0x44}, pulse load_i, ready_i=1.
  - Cycles 1..4 give data_o = 0x44, 0x33, 0x22, 0x11.
  - idx_o = 3, 2, 1, 0.
  - last_o only on the 0x11 beat.
  - Then valid_o=0, busy_o=0.
- Backpressure: same load, ready_i low for 3 cycles during the 0x33 beat.
  - data_o holds 0x33 and idx_o holds 2 throughout.
  - Beat count is exactly 4 with no duplicates.
  - Changing product_i to all 0xFF right after load does not alter any output word.
- Back-to-back: on the last-beat handshake, assert load_i with product_i = {0xA0, 0xA1, 0xA2, 0xA3}.
  - load_ready_o=1 in that cycle.
  - The next cycle shows data_o=0xA3, idx_o=3 with no idle cycle between drains.
- Overflow: pulse load_i on the second beat of a drain.
  - overflow_o goes to 1 the next cycle and the original 4 words complete intact.
  - Assert clear_err_i alone: overflow_o=0.
  - Assert drop + clear_err_i in the same cycle: overflow_o=1.
- Reset mid-operation: assert rst_ni low asynchronously (between edges) during the beat with idx_o=2.
  - valid_o and busy_o drop immediately.
  - After release, no beats appear until a new load_i.
